// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer: each word is steered by in_sel into a
// 2-entry FIFO per output channel, with valid/ready handshaking on both sides.
module demux4_buf #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready
);

  logic [WIDTH-1:0] head_q [4];
  logic [WIDTH-1:0] head_d [4];
  logic [WIDTH-1:0] tail_q [4];
  logic [WIDTH-1:0] tail_d [4];
  logic [1:0]       cnt_q  [4];
  logic [1:0]       cnt_d  [4];
  logic             push;

  // Ready looks only at the selected channel's fill level: no pass-through
  // from out_ready, so a full channel stays refused even while it drains.
  assign in_ready = rst_n & (cnt_q[in_sel] != 2'd2);
  assign push     = in_valid & in_ready;

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k]                  = (cnt_q[k] != 2'd0);
      out_data[k*WIDTH +: WIDTH]    = head_q[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      logic psh;
      logic pop;
      head_d[k] = head_q[k];
      tail_d[k] = tail_q[k];
      cnt_d[k]  = cnt_q[k];
      psh       = push && (in_sel == 2'(k));
      pop       = out_valid[k] && out_ready[k];
      case (cnt_q[k])
        2'd0: begin
          if (psh) begin
            head_d[k] = in_data;
            cnt_d[k]  = 2'd1;
          end
        end
        2'd1: begin
          if (psh && pop) begin
            head_d[k] = in_data;
          end else if (psh) begin
            tail_d[k] = in_data;
            cnt_d[k]  = 2'd2;
          end else if (pop) begin
            // Empty head is kept at zero so the output lane reads 0.
            head_d[k] = '0;
            cnt_d[k]  = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d[k] = tail_q[k];
            tail_d[k] = '0;
            cnt_d[k]  = 2'd1;
          end
        end
        default: begin
          cnt_d[k] = cnt_q[k];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        head_q[k] <= '0;
        tail_q[k] <= '0;
        cnt_q[k]  <= 2'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        head_q[k] <= head_d[k];
        tail_q[k] <= tail_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

endmodule
